// File: rtl/eeprom_i2c_pkg.sv
// Shared constants and FSM state encoding for the 24C16-class I2C EEPROM responder.
package eeprom_i2c_pkg;

  localparam logic [3:0]  CTRL_CODE  = 4'b1010;
  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_PAGE_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CTRL,
    ST_CTRL_ACK,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } state_e;

endpackage

// File: rtl/eeprom_i2c_slave_sync.sv
// SCL/SDA synchronizers with one history flop each; produces edge and START/STOP strobes.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_hist_q;
  logic                   sda_hist_q;
  logic                   scl_s;
  logic                   sda_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // START/STOP need SCL high on both samples, so a coincident SCL edge wins.
  assign scl_rise_o  =  scl_s & ~scl_hist_q;
  assign scl_fall_o  = ~scl_s &  scl_hist_q;
  assign start_det_o =  scl_s &  scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det_o  =  scl_s &  scl_hist_q & ~sda_hist_q &  sda_s;
  assign sda_s_o     =  sda_s;

endmodule

// File: rtl/eeprom_i2c_slave.sv
// I2C responder modelling a 2 KB serial EEPROM: byte/page write, random and sequential read.
module eeprom_i2c_slave
  import eeprom_i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned PAGE_W      = DEF_PAGE_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              BUSY,
  output logic              WR_PULSE,
  output logic [ADDR_W-1:0] CUR_ADDR
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (CLK),
    .rst_n_i    (RESET),
    .scl_i      (SCL),
    .sda_i      (SDA),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [7:0]        rx_byte;
  logic [7:0]        mem_rd;
  logic              mem_we;

  logic [7:0] mem [0:2**ADDR_W-1];

  assign mem_rd  = mem[cur_addr_q];
  assign rx_byte = {shift_q[6:0], sda_s};

  always_ff @(posedge CLK) begin
    if (mem_we) mem[cur_addr_q] <= rx_byte;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd7;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      cur_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      cur_addr_q <= cur_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    cur_addr_d = cur_addr_q;
    wr_pulse_d = 1'b0;
    mem_we     = 1'b0;
    if (start_det) begin
      state_d  = ST_CTRL;
      bitcnt_d = 3'd7;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_CTRL, ST_ADDR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q - 3'd1;
            if (bitcnt_q == 3'd0) begin
              bitcnt_d = 3'd7;
              if (state_q == ST_CTRL) begin
                if (rx_byte[7:4] == CTRL_CODE) begin
                  cur_addr_d[ADDR_W-1:8] = rx_byte[ADDR_W-8:1];
                  state_d = ST_CTRL_ACK;
                end else begin
                  state_d = ST_IDLE;
                end
              end else if (state_q == ST_ADDR) begin
                cur_addr_d[7:0] = rx_byte;
                state_d = ST_ADDR_ACK;
              end else begin
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                cur_addr_d[PAGE_W-1:0] = cur_addr_q[PAGE_W-1:0] + 1'b1;
                state_d = ST_WDATA_ACK;
              end
            end
          end
        end
        // First fall after the 8th bit starts the ACK; the next fall ends it.
        ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              bitcnt_d = 3'd7;
              if (state_q == ST_CTRL_ACK && shift_q[0]) begin
                shift_d  = mem_rd;
                sda_oe_d = ~mem_rd[7];
                state_d  = ST_RDATA;
              end else if (state_q == ST_CTRL_ACK) begin
                state_d = ST_ADDR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              state_d  = ST_RDATA_ACK;
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            cur_addr_d = cur_addr_q + 1'b1;
            if (sda_s) state_d = ST_IDLE;
          end else if (scl_fall) begin
            shift_d  = mem_rd;
            sda_oe_d = ~mem_rd[7];
            bitcnt_d = 3'd7;
            state_d  = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign BUSY     = busy_q;
  assign WR_PULSE = wr_pulse_q;
  assign CUR_ADDR = cur_addr_q;

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Directed plus randomized I2C master bench with a byte-array reference model of the EEPROM.
module tb_eeprom_i2c_slave;

  typedef logic [7:0] bq_t [$];

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_low = 1'b0;
  wire         sda;
  logic        busy;
  logic        wr_pulse;
  logic [10:0] cur_addr;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [7:0] model_mem   [0:2047];
  bit         model_valid [0:2047];
  int         model_cur = 0;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_pulse === 1'b1) wr_cnt++;

  eeprom_i2c_slave #(.SYNC_STAGES(2), .ADDR_W(11), .PAGE_W(4)) dut (
    .CLK     (clk),
    .RESET   (rst_n),
    .SCL     (scl_m),
    .SDA     (sda),
    .BUSY    (busy),
    .WR_PULSE(wr_pulse),
    .CUR_ADDR(cur_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    tick(Q); sda_low = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_low = 1'b1;
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(Q); sda_low = 1'b1;
    tick(Q); scl_m = 1'b1;
    tick(Q); sda_low = 1'b0;
    tick(2*Q);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); sda_low = ~b;
    tick(Q); scl_m = 1'b1;
    tick(2*Q); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(Q); sda_low = 1'b0;
    tick(Q); scl_m = 1'b1;
    tick(Q); b = (sda !== 1'b0);
    tick(Q); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  task automatic do_write(input int a, input bq_t data);
    logic ack;
    int   base;
    base = wr_cnt;
    i2c_start();
    send_byte({4'hA, 3'(a >> 8), 1'b0}, ack); check("wr_ctrl_ack", ack, 1);
    send_byte(8'(a), ack);                    check("wr_addr_ack", ack, 1);
    foreach (data[i]) begin
      send_byte(data[i], ack);                check("wr_data_ack", ack, 1);
    end
    i2c_stop();
    model_cur = a;
    foreach (data[i]) begin
      model_mem[model_cur]   = data[i];
      model_valid[model_cur] = 1'b1;
      model_cur = (model_cur & 32'h7F0) | ((model_cur + 1) % 16);
    end
    check("wr_pulses", wr_cnt - base, data.size());
    check("wr_cur_addr", 32'(cur_addr), model_cur);
    check("wr_busy_after_stop", busy, 0);
  endtask

  task automatic do_read(input int a, input int n);
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte({4'hA, 3'(a >> 8), 1'b0}, ack); check("rd_dummy_ctrl_ack", ack, 1);
    send_byte(8'(a), ack);                    check("rd_addr_ack", ack, 1);
    i2c_start();
    send_byte({4'hA, 3'(a >> 8), 1'b1}, ack); check("rd_ctrl_ack", ack, 1);
    model_cur = a;
    for (int i = 0; i < n; i++) begin
      recv_byte(i != n - 1, d);
      if (model_valid[model_cur]) check("rd_data", d, model_mem[model_cur]);
      model_cur = (model_cur + 1) % 2048;
    end
    i2c_stop();
    check("rd_cur_addr", 32'(cur_addr), model_cur);
    check("rd_busy_after_stop", busy, 0);
  endtask

  initial begin
    bq_t        q;
    logic       ack;
    int         base;
    int         a;
    int         n;

    // Reset state
    tick(5);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_cur_addr", 32'(cur_addr), 0);
    rst_n = 1'b1;
    tick(5);

    // Byte write then random read of the same location
    q = {}; q.push_back(8'h5A);
    do_write(32'h235, q);
    do_read(32'h235, 1);

    // Page write wrapping within a 16-byte page
    q = {}; q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    do_write(32'h00E, q);
    do_read(32'h00E, 2);
    do_read(32'h000, 1);

    // Sequential read wrapping across the top of the array
    q = {}; q.push_back(8'hC3); do_write(32'h7FF, q);
    q = {}; q.push_back(8'h3C); do_write(32'h000, q);
    do_read(32'h7FF, 2);

    // Wrong device code: no ACKs and no writes
    base = wr_cnt;
    i2c_start();
    send_byte(8'h90, ack); check("bad_ctrl_nack", ack, 0);
    send_byte(8'h55, ack); check("bad_addr_nack", ack, 0);
    send_byte(8'h66, ack); check("bad_data_nack", ack, 0);
    i2c_stop();
    check("bad_no_write", wr_cnt - base, 0);
    check("bad_cur_addr", 32'(cur_addr), model_cur);

    // Reset while the slave is driving a 0 data bit
    q = {}; q.push_back(8'h00); do_write(32'h100, q);
    i2c_start();
    send_byte(8'hA2, ack); check("mid_ctrl_ack", ack, 1);
    send_byte(8'h00, ack); check("mid_addr_ack", ack, 1);
    i2c_start();
    send_byte(8'hA3, ack); check("mid_rctrl_ack", ack, 1);
    tick(Q);
    check("mid_bit_driven", sda, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sda_released", sda, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cur_addr", 32'(cur_addr), 0);
    tick(3);
    rst_n = 1'b1;
    model_cur = 0;
    tick(2);
    q = {}; q.push_back(8'hE7); do_write(32'h123, q);
    do_read(32'h100, 2);

    // Randomized page writes followed by random reads
    for (int t = 0; t < 6; t++) begin
      a = $urandom_range(0, 2047);
      n = $urandom_range(1, 18);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_write(a, q);
      do_read(a, $urandom_range(1, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
